// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: opcodes, instruction field
// positions, the scoreboard entry type and per-opcode operand usage.
package hazard_pkg;

    localparam int unsigned OPC_W     = 5;
    localparam int unsigned REG_IDX_W = 4;

    localparam logic [OPC_W-1:0] OP_CMP      = 5'b00101;
    localparam logic [OPC_W-1:0] OP_NOT      = 5'b01000;
    localparam logic [OPC_W-1:0] OP_MOV      = 5'b01001;
    localparam logic [OPC_W-1:0] OP_ALU_LAST = 5'b01100;
    localparam logic [OPC_W-1:0] OP_NOP      = 5'b01101;
    localparam logic [OPC_W-1:0] OP_LD       = 5'b01110;
    localparam logic [OPC_W-1:0] OP_ST       = 5'b01111;
    localparam logic [OPC_W-1:0] OP_BEQ      = 5'b10000;
    localparam logic [OPC_W-1:0] OP_BGT      = 5'b10001;
    localparam logic [OPC_W-1:0] OP_B        = 5'b10010;
    localparam logic [OPC_W-1:0] OP_CALL     = 5'b10011;
    localparam logic [OPC_W-1:0] OP_RET      = 5'b10100;

    localparam int unsigned OPC_HI  = 31;
    localparam int unsigned OPC_LO  = 27;
    localparam int unsigned IMM_BIT = 26;
    localparam int unsigned RD_HI   = 25;
    localparam int unsigned RD_LO   = 22;
    localparam int unsigned RS1_HI  = 21;
    localparam int unsigned RS1_LO  = 18;
    localparam int unsigned RS2_HI  = 17;
    localparam int unsigned RS2_LO  = 14;

    localparam logic [REG_IDX_W-1:0] RA = '1;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] dst;
        logic                 is_load;
    } sb_entry_t;

    function automatic logic writes_reg(input logic [OPC_W-1:0] op);
        return !(op inside {OP_NOP, OP_CMP, OP_ST, OP_BEQ, OP_BGT, OP_B, OP_RET});
    endfunction

    function automatic logic reads_a(input logic [OPC_W-1:0] op);
        return !(op inside {OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_NOT, OP_MOV});
    endfunction

    function automatic logic reads_b(input logic [OPC_W-1:0] op, input logic imm);
        return !imm && (op <= OP_ALU_LAST);
    endfunction

    function automatic logic reads_d(input logic [OPC_W-1:0] op);
        return op == OP_ST;
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational instruction decode shared by the OF hazard check and the
// scoreboard entry-0 insert.
module hazard_decode
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W = 4
) (
    input  logic [31:0]      i_inst,
    output logic             o_wr,
    output logic [REG_W-1:0] o_dst,
    output logic             o_is_load,
    output logic             o_rd_a,
    output logic [REG_W-1:0] o_src_a,
    output logic             o_rd_b,
    output logic [REG_W-1:0] o_src_b,
    output logic             o_rd_d,
    output logic [REG_W-1:0] o_src_d
);

    logic [OPC_W-1:0] w_opc;
    logic             w_imm;
    logic [REG_W-1:0] w_rd;
    logic [REG_W-1:0] w_rs1;
    logic [REG_W-1:0] w_rs2;
    logic             w_unused;

    assign w_opc    = i_inst[OPC_HI:OPC_LO];
    assign w_imm    = i_inst[IMM_BIT];
    assign w_rd     = i_inst[RD_HI:RD_LO];
    assign w_rs1    = i_inst[RS1_HI:RS1_LO];
    assign w_rs2    = i_inst[RS2_HI:RS2_LO];
    assign w_unused = ^i_inst[RS2_LO-1:0];

    // CALL links into ra; RET reads its return address from ra.
    assign o_wr      = writes_reg(w_opc);
    assign o_dst     = (w_opc == OP_CALL) ? RA : w_rd;
    assign o_is_load = (w_opc == OP_LD);
    assign o_rd_a    = reads_a(w_opc);
    assign o_src_a   = (w_opc == OP_RET) ? RA : w_rs1;
    assign o_rd_b    = reads_b(w_opc, w_imm);
    assign o_src_b   = w_rs2;
    assign o_rd_d    = reads_d(w_opc);
    assign o_src_d   = w_rd;

endmodule

// File: rtl/hazard_scoreboard.sv
// Data-hazard unit: shift-register scoreboard of in-flight writers, per-operand
// forwarding selects, load-use/interlock stall and saturating perf counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W  = 4,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned FWD_EN = 1,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned SEL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [31:0]      id_inst,
    input  logic             flush,
    input  logic             hold,
    output logic             stall,
    output logic [SEL_W-1:0] fwd_sel_a,
    output logic [SEL_W-1:0] fwd_sel_b,
    output logic [SEL_W-1:0] fwd_sel_d,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] fwd_cnt
);

    typedef struct packed {
        logic             hit;
        logic [SEL_W-1:0] sel;
        logic             load_use;
    } match_t;

    sb_entry_t [DEPTH-1:0] r_sb;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_fwd_cnt;

    logic             w_wr;
    logic [REG_W-1:0] w_dst;
    logic             w_is_load;
    logic             w_rd_a;
    logic [REG_W-1:0] w_src_a;
    logic             w_rd_b;
    logic [REG_W-1:0] w_src_b;
    logic             w_rd_d;
    logic [REG_W-1:0] w_src_d;
    match_t           w_ma;
    match_t           w_mb;
    match_t           w_md;
    logic             w_active;
    logic             w_stall;
    logic [SEL_W-1:0] w_sel_a;
    logic [SEL_W-1:0] w_sel_b;
    logic [SEL_W-1:0] w_sel_d;
    logic             w_issue;
    logic             w_fwd_any;
    sb_entry_t        w_new;

    hazard_decode #(.REG_W(REG_W)) u_decode (
        .i_inst    (id_inst),
        .o_wr      (w_wr),
        .o_dst     (w_dst),
        .o_is_load (w_is_load),
        .o_rd_a    (w_rd_a),
        .o_src_a   (w_src_a),
        .o_rd_b    (w_rd_b),
        .o_src_b   (w_src_b),
        .o_rd_d    (w_rd_d),
        .o_src_d   (w_src_d)
    );

    // Scan from entry 0 upward so the youngest matching writer wins.
    function automatic match_t find_match(input logic rd, input logic [REG_W-1:0] src,
                                          input sb_entry_t [DEPTH-1:0] sb);
        match_t m;
        m = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (rd && !m.hit && sb[k].valid && (sb[k].dst == src)) begin
                m.hit      = 1'b1;
                m.sel      = SEL_W'(k + 1);
                m.load_use = (k == 0) && sb[k].is_load;
            end
        end
        return m;
    endfunction

    assign w_ma     = find_match(w_rd_a, w_src_a, r_sb);
    assign w_mb     = find_match(w_rd_b, w_src_b, r_sb);
    assign w_md     = find_match(w_rd_d, w_src_d, r_sb);
    assign w_active = id_valid && !flush;

    always_comb begin
        w_stall = 1'b0;
        w_sel_a = '0;
        w_sel_b = '0;
        w_sel_d = '0;
        if (w_active) begin
            if (FWD_EN != 0) begin
                w_stall = w_ma.load_use || w_mb.load_use || w_md.load_use;
                w_sel_a = w_ma.sel;
                w_sel_b = w_mb.sel;
                w_sel_d = w_md.sel;
            end else begin
                w_stall = w_ma.hit || w_mb.hit || w_md.hit;
            end
        end
    end

    assign w_issue   = id_valid && !w_stall && !flush;
    assign w_fwd_any = |{w_sel_a, w_sel_b, w_sel_d};

    always_comb begin
        w_new         = '0;
        w_new.valid   = w_issue && w_wr;
        w_new.dst     = w_dst;
        w_new.is_load = w_is_load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb        <= '0;
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else if (!hold) begin
            r_sb <= {r_sb[DEPTH-2:0], w_new};
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_issue && w_fwd_any && (r_fwd_cnt != '1)) begin
                r_fwd_cnt <= r_fwd_cnt + 1'b1;
            end
        end
    end

    assign stall     = w_stall;
    assign fwd_sel_a = w_sel_a;
    assign fwd_sel_b = w_sel_b;
    assign fwd_sel_d = w_sel_d;
    assign stall_cnt = r_stall_cnt;
    assign fwd_cnt   = r_fwd_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding, interlock and saturating
// counter instances driven from one shared stimulus stream.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_inst = '0;
    logic        flush = 1'b0;
    logic        hold = 1'b0;

    logic        stall, il_stall, sat_stall;
    logic [1:0]  sel_a, sel_b, sel_d;
    logic [1:0]  il_sel_a, il_sel_b, il_sel_d;
    logic [1:0]  sat_sel_a, sat_sel_b, sat_sel_d;
    logic [15:0] stall_cnt, fwd_cnt, il_stall_cnt, il_fwd_cnt;
    logic [1:0]  sat_stall_cnt, sat_fwd_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, CMP = 5'b00101, MOV = 5'b01001;
    localparam logic [4:0] LD = 5'b01110, ST = 5'b01111, CALL = 5'b10011, RET = 5'b10100;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .flush(flush), .hold(hold),
        .stall(stall), .fwd_sel_a(sel_a), .fwd_sel_b(sel_b), .fwd_sel_d(sel_d),
        .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
    );

    hazard_scoreboard #(.FWD_EN(0)) dut_il (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .flush(flush), .hold(hold),
        .stall(il_stall), .fwd_sel_a(il_sel_a), .fwd_sel_b(il_sel_b), .fwd_sel_d(il_sel_d),
        .stall_cnt(il_stall_cnt), .fwd_cnt(il_fwd_cnt)
    );

    hazard_scoreboard #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .flush(flush), .hold(hold),
        .stall(sat_stall), .fwd_sel_a(sat_sel_a), .fwd_sel_b(sat_sel_b), .fwd_sel_d(sat_sel_d),
        .stall_cnt(sat_stall_cnt), .fwd_cnt(sat_fwd_cnt)
    );

    function automatic logic [31:0] enc(input logic [4:0] op, input logic imm, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, imm, rd, rs1, rs2, 14'b0};
    endfunction

    task automatic drive(input logic v, input logic [31:0] inst, input logic f, input logic h);
        @(negedge clk);
        id_valid = v;
        id_inst  = inst;
        flush    = f;
        hold     = h;
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; id_valid = 1'b0; flush = 1'b0; hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; id_valid = 1'b1; id_inst = enc(ADD, 1'b0, 4'd1, 4'd2, 4'd3);
        @(negedge clk); #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0d exp 0", stall); end
        n_checks++; if ({sel_a, sel_b, sel_d} !== 6'd0) begin n_fail++; $display("FAIL reset_sel: got %0h exp 0", {sel_a, sel_b, sel_d}); end
        n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d exp 0", stall_cnt); end
        n_checks++; if (fwd_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_fwd_cnt: got %0d exp 0", fwd_cnt); end
        rst = 1'b0; id_valid = 1'b0;
    endtask

    task automatic test_forward_alu;
        do_reset();
        drive(1'b1, enc(ADD, 1'b0, 4'd3, 4'd1, 4'd2), 1'b0, 1'b0);
        drive(1'b1, enc(SUB, 1'b0, 4'd4, 4'd3, 4'd5), 1'b0, 1'b0);
        n_checks++; if (sel_a !== 2'd1) begin n_fail++; $display("FAIL alu_sel_a: got %0d exp 1", sel_a); end
        n_checks++; if (sel_b !== 2'd0) begin n_fail++; $display("FAIL alu_sel_b: got %0d exp 0", sel_b); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %0d exp 0", stall); end
        drive(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (fwd_cnt !== 16'd1) begin n_fail++; $display("FAIL alu_fwd_cnt: got %0d exp 1", fwd_cnt); end
    endtask

    task automatic test_load_use;
        do_reset();
        drive(1'b1, enc(LD, 1'b1, 4'd6, 4'd1, 4'd0), 1'b0, 1'b0);
        drive(1'b1, enc(ADD, 1'b0, 4'd7, 4'd6, 4'd2), 1'b0, 1'b0);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall1: got %0d exp 1", stall); end
        drive(1'b1, enc(ADD, 1'b0, 4'd7, 4'd6, 4'd2), 1'b0, 1'b0);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall2: got %0d exp 0", stall); end
        n_checks++; if (sel_a !== 2'd2) begin n_fail++; $display("FAIL lu_sel_a: got %0d exp 2", sel_a); end
        drive(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d exp 1", stall_cnt); end
        n_checks++; if (fwd_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_fwd_cnt: got %0d exp 1", fwd_cnt); end
    endtask

    task automatic test_call_ret;
        do_reset();
        drive(1'b1, enc(CALL, 1'b1, 4'd0, 4'd0, 4'd0), 1'b0, 1'b0);
        drive(1'b1, enc(CMP, 1'b0, 4'd0, 4'd15, 4'd1), 1'b0, 1'b0);
        n_checks++; if (sel_a !== 2'd1) begin n_fail++; $display("FAIL cmp_ra_sel_a: got %0d exp 1", sel_a); end
        drive(1'b1, enc(RET, 1'b0, 4'd0, 4'd0, 4'd0), 1'b0, 1'b0);
        n_checks++; if (sel_a !== 2'd2) begin n_fail++; $display("FAIL ret_sel_a: got %0d exp 2", sel_a); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ret_stall: got %0d exp 0", stall); end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_store_fwd;
        do_reset();
        drive(1'b1, enc(MOV, 1'b1, 4'd2, 4'd0, 4'd0), 1'b0, 1'b0);
        drive(1'b1, enc(ST, 1'b1, 4'd2, 4'd1, 4'd0), 1'b0, 1'b0);
        n_checks++; if (sel_d !== 2'd1) begin n_fail++; $display("FAIL st_sel_d: got %0d exp 1", sel_d); end
        n_checks++; if (sel_a !== 2'd0) begin n_fail++; $display("FAIL st_sel_a: got %0d exp 0", sel_a); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL st_stall: got %0d exp 0", stall); end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_interlock;
        do_reset();
        drive(1'b1, enc(MOV, 1'b1, 4'd2, 4'd0, 4'd0), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, enc(ST, 1'b1, 4'd2, 4'd1, 4'd0), 1'b0, 1'b0);
            n_checks++; if (il_stall !== 1'b1) begin n_fail++; $display("FAIL il_stall_c%0d: got %0d exp 1", i, il_stall); end
            n_checks++; if ({il_sel_a, il_sel_b, il_sel_d} !== 6'd0) begin n_fail++; $display("FAIL il_sel_c%0d: got %0h exp 0", i, {il_sel_a, il_sel_b, il_sel_d}); end
        end
        drive(1'b1, enc(ST, 1'b1, 4'd2, 4'd1, 4'd0), 1'b0, 1'b0);
        n_checks++; if (il_stall !== 1'b0) begin n_fail++; $display("FAIL il_release: got %0d exp 0", il_stall); end
        n_checks++; if (il_stall_cnt !== 16'd3) begin n_fail++; $display("FAIL il_stall_cnt: got %0d exp 3", il_stall_cnt); end
        drive(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (il_fwd_cnt !== 16'd0) begin n_fail++; $display("FAIL il_fwd_cnt: got %0d exp 0", il_fwd_cnt); end
    endtask

    task automatic test_flush;
        do_reset();
        drive(1'b1, enc(LD, 1'b1, 4'd6, 4'd1, 4'd0), 1'b0, 1'b0);
        drive(1'b1, enc(ADD, 1'b0, 4'd7, 4'd6, 4'd2), 1'b1, 1'b0);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %0d exp 0", stall); end
        n_checks++; if (sel_a !== 2'd0) begin n_fail++; $display("FAIL flush_sel_a: got %0d exp 0", sel_a); end
        drive(1'b1, enc(SUB, 1'b0, 4'd8, 4'd7, 4'd6), 1'b0, 1'b0);
        n_checks++; if (sel_a !== 2'd0) begin n_fail++; $display("FAIL flush_bubble_sel_a: got %0d exp 0", sel_a); end
        n_checks++; if (sel_b !== 2'd2) begin n_fail++; $display("FAIL flush_sel_b: got %0d exp 2", sel_b); end
        n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL flush_stall_cnt: got %0d exp 0", stall_cnt); end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_hold;
        do_reset();
        drive(1'b1, enc(LD, 1'b1, 4'd6, 4'd1, 4'd0), 1'b0, 1'b0);
        drive(1'b1, enc(ADD, 1'b0, 4'd7, 4'd6, 4'd2), 1'b0, 1'b1);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL hold_stall0: got %0d exp 1", stall); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, enc(ADD, 1'b0, 4'd7, 4'd6, 4'd2), 1'b0, 1'b1);
            n_checks++; if (sel_a !== 2'd1) begin n_fail++; $display("FAIL hold_frozen_c%0d: got sel_a %0d exp 1", i, sel_a); end
            n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL hold_stall_cnt_c%0d: got %0d exp 0", i, stall_cnt); end
        end
        drive(1'b1, enc(ADD, 1'b0, 4'd7, 4'd6, 4'd2), 1'b0, 1'b0);
        drive(1'b1, enc(ADD, 1'b0, 4'd7, 4'd6, 4'd2), 1'b0, 1'b0);
        n_checks++; if (stall !== 1'b0 || sel_a !== 2'd2) begin n_fail++; $display("FAIL hold_release: got stall %0d sel_a %0d exp 0 2", stall, sel_a); end
        n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL hold_stall_cnt_after: got %0d exp 1", stall_cnt); end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_saturation;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, enc(LD, 1'b1, 4'd6, 4'd1, 4'd0), 1'b0, 1'b0);
            drive(1'b1, enc(ADD, 1'b0, 4'd7, 4'd6, 4'd2), 1'b0, 1'b0);
            drive(1'b1, enc(ADD, 1'b0, 4'd7, 4'd6, 4'd2), 1'b0, 1'b0);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (sat_stall_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_stall_cnt: got %0d exp 3", sat_stall_cnt); end
        n_checks++; if (sat_fwd_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_fwd_cnt: got %0d exp 3", sat_fwd_cnt); end
        n_checks++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL wide_stall_cnt: got %0d exp 4", stall_cnt); end
        n_checks++; if (fwd_cnt !== 16'd4) begin n_fail++; $display("FAIL wide_fwd_cnt: got %0d exp 4", fwd_cnt); end
    endtask

    task automatic test_reset_mid_stall;
        drive(1'b1, enc(LD, 1'b1, 4'd6, 4'd1, 4'd0), 1'b0, 1'b0);
        drive(1'b1, enc(ADD, 1'b0, 4'd7, 4'd6, 4'd2), 1'b0, 1'b0);
        n_checks++; if (sat_stall !== 1'b1) begin n_fail++; $display("FAIL mid_pre_stall: got %0d exp 1", sat_stall); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b0 || sat_stall !== 1'b0) begin n_fail++; $display("FAIL mid_stall: got %0d/%0d exp 0", stall, sat_stall); end
        n_checks++; if (sel_a !== 2'd0) begin n_fail++; $display("FAIL mid_sel_a: got %0d exp 0", sel_a); end
        n_checks++; if (stall_cnt !== 16'd0 || sat_stall_cnt !== 2'd0) begin n_fail++; $display("FAIL mid_stall_cnt: got %0d/%0d exp 0", stall_cnt, sat_stall_cnt); end
        n_checks++; if (fwd_cnt !== 16'd0 || sat_fwd_cnt !== 2'd0) begin n_fail++; $display("FAIL mid_fwd_cnt: got %0d/%0d exp 0", fwd_cnt, sat_fwd_cnt); end
        @(negedge clk);
        rst = 1'b0; id_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_forward_alu();
        test_load_use();
        test_call_ret();
        test_store_fwd();
        test_interlock();
        test_flush();
        test_hold();
        test_saturation();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
